// File: rtl/syscall_unit.sv
// syscall_unit: services the controller's HALT/READ/WRITE syscalls over rx/tx valid-ready word streams.
// Latency: READ/WRITE reach DONE two edges after runio is first sampled high, plus one edge per stalled handshake cycle.
// Backpressure: RD/WR wait for rx_valid/tx_ready; with `SYSCALL_TIMEOUT_EN they give up after TIMEOUT_CYCLES.
module syscall_unit #(
  parameter int WIDTH          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             runio,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] dr_in,
  output logic             iobusy,
  output logic [WIDTH-1:0] io_result,
  output logic             io_acc_write,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             halted,
  output logic             io_error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    WR      = 3'd2,
    HALT    = 3'd3,
    DONE    = 3'd4,
    RELEASE = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       code_q;
  logic [WIDTH-1:0] arg_q;
  logic             handshake;
  logic             timed_out;
  logic             timeout_hit;
  logic             unused_acc;

  assign unused_acc  = ^acc_in[WIDTH-1:2];
  assign handshake   = (state == RD && rx_valid) || (state == WR && tx_ready);
  // A handshake on the limit edge completes normally.
  assign timeout_hit = timed_out && !handshake;

`ifdef SYSCALL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  assign timed_out = (state == RD || state == WR) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if ((state == RD || state == WR) && state_nxt == state) begin
      wait_cnt <= wait_cnt + CW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign timed_out      = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    iobusy    = 1'b0;
    rx_ready  = 1'b0;
    tx_valid  = 1'b0;
    case (state)
      IDLE: begin
        // Busy as soon as runio rises so the controller never sees a false idle.
        iobusy = runio;
        if (runio) begin
          case (acc_in[1:0])
            2'd0:    state_nxt = HALT;
            2'd1:    state_nxt = RD;
            2'd2:    state_nxt = WR;
            default: state_nxt = DONE;
          endcase
        end
      end
      RD: begin
        iobusy   = 1'b1;
        rx_ready = 1'b1;
        if (rx_valid || timed_out) state_nxt = DONE;
      end
      WR: begin
        iobusy   = 1'b1;
        tx_valid = 1'b1;
        if (tx_ready || timed_out) state_nxt = DONE;
      end
      HALT: begin
        iobusy = 1'b1;
      end
      DONE: begin
        state_nxt = runio ? RELEASE : IDLE;
      end
      RELEASE: begin
        if (!runio) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign tx_data      = arg_q;
  assign io_acc_write = (state == DONE) && (code_q == 2'd1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      code_q    <= 2'd0;
      arg_q     <= '0;
      io_result <= '0;
      halted    <= 1'b0;
      io_error  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && runio) begin
        code_q <= acc_in[1:0];
        arg_q  <= dr_in;
      end
      if (state == RD) begin
        if (rx_valid)       io_result <= rx_data;
        else if (timed_out) io_result <= '1;
      end
      if (state_nxt == HALT) halted <= 1'b1;
      if ((state == IDLE && runio && acc_in[1:0] == 2'd3) || timeout_hit) io_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_syscall_unit.sv
// Bench for syscall_unit: directed syscall scenarios plus randomized calls against a transaction-level model.
`timescale 1ns/1ps
module tb_syscall_unit;
  localparam int W  = 16;
  localparam int TO = 8;
`ifdef SYSCALL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         runio = 1'b0;
  logic [W-1:0] acc_in = '0;
  logic [W-1:0] dr_in = '0;
  logic         iobusy;
  logic [W-1:0] io_result;
  logic         io_acc_write;
  logic [W-1:0] rx_data = '0;
  logic         rx_valid = 1'b0;
  logic         rx_ready;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic         halted;
  logic         io_error;

  syscall_unit #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .runio(runio), .acc_in(acc_in), .dr_in(dr_in),
    .iobusy(iobusy), .io_result(io_result), .io_acc_write(io_acc_write),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .halted(halted), .io_error(io_error)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Model state: what io_result and io_error must hold after the calls so far.
  logic [W-1:0] m_result = '0;
  logic         m_error  = 1'b0;

  // Observations of the last call.
  int o_busy, o_rdy, o_vld, o_accw, o_accw_at, o_txbad, o_post_busy;

  task automatic apply_reset();
    @(posedge clock); #1;
    reset = 1'b0; runio = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    m_result = '0;
    m_error  = 1'b0;
  endtask

  // Controller-style call: raise runio, stall the handshake `delay` cycles, hold runio
  // `hold` extra edges after iobusy drops, then watch a few idle cycles.
  task automatic run_call(input logic [1:0] code, input logic [W-1:0] arg,
                          input logic [W-1:0] word, input int delay, input int hold);
    int waits;
    bit done;
    logic [W-1:0] a;
    @(posedge clock); #1;
    a = W'($urandom);
    a[1:0] = code;
    acc_in = a; dr_in = arg; rx_data = word;
    rx_valid = (delay == 0); tx_ready = (delay == 0);
    runio = 1'b1;
    o_busy = 0; o_rdy = 0; o_vld = 0; o_accw = 0; o_accw_at = -1; o_txbad = 0; o_post_busy = 0;
    waits = 0; done = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clock);
      if (rx_ready) begin waits++; o_rdy++; end
      if (tx_valid) begin waits++; o_vld++; if (tx_data !== arg) o_txbad++; end
      if (io_acc_write) begin o_accw++; if (o_accw_at < 0) o_accw_at = cyc; end
      if (iobusy) o_busy++;
      else done = 1'b1;
      if (!done) begin
        @(posedge clock); #1;
        rx_valid = (waits >= delay);
        tx_ready = (waits >= delay);
      end
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL call_wait: iobusy never dropped within 300 cycles (code %0d)", code);
    end
    if (hold == 0) runio = 1'b0;
    rx_valid = 1'b1; tx_ready = 1'b1;
    for (int k = 0; k < hold + 3; k++) begin
      @(posedge clock); #1;
      if (k == hold - 1) runio = 1'b0;
      @(negedge clock);
      o_rdy += int'(rx_ready);
      o_vld += int'(tx_valid);
      o_accw += int'(io_acc_write);
      o_post_busy += int'(iobusy);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clock);
    vectors++; if ({iobusy, io_acc_write, halted, io_error, rx_ready, tx_valid} !== 6'b0) begin
      miscompares++; $display("FAIL reset_flags: got %b want 000000", {iobusy, io_acc_write, halted, io_error, rx_ready, tx_valid}); end
    vectors++; if (io_result !== 16'h0) begin
      miscompares++; $display("FAIL reset_result: got %h want 0000", io_result); end
  endtask

  task automatic test_read();
    run_call(2'd1, 16'h5555, 16'h1234, 0, 0);
    m_result = 16'h1234;
    vectors++; if (o_busy !== 2) begin miscompares++; $display("FAIL read_busy: got %0d want 2", o_busy); end
    vectors++; if (io_result !== 16'h1234) begin miscompares++; $display("FAIL read_result: got %h want 1234", io_result); end
    vectors++; if (o_accw !== 1) begin miscompares++; $display("FAIL read_accw_count: got %0d want 1", o_accw); end
    vectors++; if (o_accw_at !== 2) begin miscompares++; $display("FAIL read_accw_cycle: got %0d want 2", o_accw_at); end
    vectors++; if (o_rdy !== 1) begin miscompares++; $display("FAIL read_rdy: got %0d want 1", o_rdy); end
  endtask

  task automatic test_write();
    run_call(2'd2, 16'hBEEF, 16'h0F0F, 5, 0);
    vectors++; if (o_vld !== 6) begin miscompares++; $display("FAIL write_vld: got %0d want 6", o_vld); end
    vectors++; if (o_txbad !== 0) begin miscompares++; $display("FAIL write_txdata: got %0d bad beats want 0", o_txbad); end
    vectors++; if (o_accw !== 0) begin miscompares++; $display("FAIL write_accw: got %0d want 0", o_accw); end
    vectors++; if (o_busy !== 7) begin miscompares++; $display("FAIL write_busy: got %0d want 7", o_busy); end
    vectors++; if (io_result !== m_result) begin miscompares++; $display("FAIL write_result: got %h want %h", io_result, m_result); end
    vectors++; if (o_post_busy !== 0) begin miscompares++; $display("FAIL write_post_busy: got %0d want 0", o_post_busy); end
  endtask

  task automatic test_code3();
    logic [W-1:0] w;
    run_call(2'd3, 16'h0, 16'h0, 0, 1);
    m_error = 1'b1;
    vectors++; if (o_busy !== 1) begin miscompares++; $display("FAIL code3_busy: got %0d want 1", o_busy); end
    vectors++; if (io_error !== 1'b1) begin miscompares++; $display("FAIL code3_error: got %b want 1", io_error); end
    vectors++; if (o_accw !== 0) begin miscompares++; $display("FAIL code3_accw: got %0d want 0", o_accw); end
    w = W'($urandom);
    run_call(2'd1, 16'h0, w, 2, 0);
    m_result = w;
    vectors++; if (io_result !== w) begin miscompares++; $display("FAIL code3_read_result: got %h want %h", io_result, w); end
    vectors++; if (io_error !== 1'b1) begin miscompares++; $display("FAIL code3_sticky: got %b want 1", io_error); end
  endtask

  task automatic test_release();
    logic [W-1:0] w;
    run_call(2'd2, 16'hA5A5, 16'h0, 0, 4);
    vectors++; if (o_vld !== 1) begin miscompares++; $display("FAIL release_vld: got %0d want 1", o_vld); end
    vectors++; if (o_rdy !== 0) begin miscompares++; $display("FAIL release_rdy: got %0d want 0", o_rdy); end
    vectors++; if (o_post_busy !== 0) begin miscompares++; $display("FAIL release_busy: got %0d want 0", o_post_busy); end
    w = W'($urandom);
    run_call(2'd1, 16'h0, w, 1, 0);
    m_result = w;
    vectors++; if (o_rdy !== 2) begin miscompares++; $display("FAIL release_next_rdy: got %0d want 2", o_rdy); end
    vectors++; if (o_accw !== 1) begin miscompares++; $display("FAIL release_next_accw: got %0d want 1", o_accw); end
    vectors++; if (io_result !== w) begin miscompares++; $display("FAIL release_next_result: got %h want %h", io_result, w); end
  endtask

  task automatic test_halt();
    int bad;
    bad = 0;
    @(posedge clock); #1;
    acc_in = 16'h0100; runio = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      runio = 1'($urandom);
      rx_valid = 1'($urandom);
      tx_ready = 1'($urandom);
      acc_in = W'($urandom);
      @(negedge clock);
      if (!(halted && iobusy && !rx_ready && !tx_valid && !io_acc_write)) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL halt_hold: got %0d bad cycles want 0", bad); end
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_flag: got %b want 1", halted); end
    apply_reset();
    @(negedge clock);
    vectors++; if ({halted, iobusy} !== 2'b00) begin miscompares++; $display("FAIL halt_reset: got %b want 00", {halted, iobusy}); end
  endtask

  task automatic test_reset_mid();
    for (int c = 1; c <= 2; c++) begin
      @(posedge clock); #1;
      acc_in = W'(c); dr_in = 16'h3C3C; rx_valid = 1'b0; tx_ready = 1'b0; runio = 1'b1;
      @(posedge clock); #1;
      @(negedge clock);
      vectors++; if ({rx_ready, tx_valid} !== ((c == 1) ? 2'b10 : 2'b01)) begin
        miscompares++; $display("FAIL rstmid_active_%0d: got %b", c, {rx_ready, tx_valid}); end
      @(posedge clock); #1;
      reset = 1'b0; runio = 1'b0; rx_valid = 1'b1; tx_ready = 1'b1;
      @(posedge clock); #1;
      reset = 1'b1;
      m_result = '0; m_error = 1'b0;
      for (int k = 0; k < 2; k++) begin
        @(negedge clock);
        vectors++; if ({rx_ready, tx_valid, io_acc_write, iobusy} !== 4'b0) begin
          miscompares++; $display("FAIL rstmid_drop_%0d_%0d: got %b want 0000", c, k, {rx_ready, tx_valid, io_acc_write, iobusy}); end
        @(posedge clock); #1;
      end
      vectors++; if (io_result !== 16'h0) begin miscompares++; $display("FAIL rstmid_result_%0d: got %h want 0000", c, io_result); end
    end
  endtask

`ifdef SYSCALL_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    run_call(2'd1, 16'h0, 16'h1111, 50, 0);
    m_result = '1; m_error = 1'b1;
    vectors++; if (o_rdy !== TO) begin miscompares++; $display("FAIL to_rd_cycles: got %0d want %0d", o_rdy, TO); end
    vectors++; if (io_result !== 16'hFFFF) begin miscompares++; $display("FAIL to_result: got %h want ffff", io_result); end
    vectors++; if (io_error !== 1'b1) begin miscompares++; $display("FAIL to_error: got %b want 1", io_error); end
    vectors++; if (o_accw !== 1) begin miscompares++; $display("FAIL to_accw: got %0d want 1", o_accw); end
    apply_reset();
    run_call(2'd2, 16'h7777, 16'h0, TO - 1, 0);
    vectors++; if (o_vld !== TO) begin miscompares++; $display("FAIL to_edge_vld: got %0d want %0d", o_vld, TO); end
    vectors++; if (io_error !== 1'b0) begin miscompares++; $display("FAIL to_edge_error: got %b want 0", io_error); end
  endtask
`endif

  // Transaction-level expectations: one IDLE busy cycle, then the RD/WR wait.
  task automatic model_call(input logic [1:0] code, input logic [W-1:0] word, input int delay,
                            output int e_busy, output int e_rdy, output int e_vld, output int e_accw);
    bit to_hit;
    int wait_cycles;
    to_hit = TO_EN && (delay >= TO);
    wait_cycles = to_hit ? TO : delay + 1;
    e_busy = 1; e_rdy = 0; e_vld = 0; e_accw = 0;
    if (code == 2'd1) begin
      e_busy = 1 + wait_cycles; e_rdy = wait_cycles; e_accw = 1;
      m_result = to_hit ? '1 : word;
      m_error  = m_error | to_hit;
    end else if (code == 2'd2) begin
      e_busy = 1 + wait_cycles; e_vld = wait_cycles;
      m_error = m_error | to_hit;
    end else begin
      m_error = 1'b1;
    end
  endtask

  task automatic test_random();
    logic [1:0] code;
    logic [W-1:0] arg, word;
    int delay, hold, e_busy, e_rdy, e_vld, e_accw;
    apply_reset();
    for (int n = 0; n < 40; n++) begin
      code  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'(1 + $urandom_range(0, 1));
      arg   = W'($urandom);
      word  = W'($urandom);
      delay = $urandom_range(0, TO_EN ? TO + 3 : 6);
      hold  = $urandom_range(0, 3);
      run_call(code, arg, word, delay, hold);
      model_call(code, word, delay, e_busy, e_rdy, e_vld, e_accw);
      vectors++; if (o_busy !== e_busy) begin miscompares++; $display("FAIL rnd%0d_busy: got %0d want %0d", n, o_busy, e_busy); end
      vectors++; if (o_rdy !== e_rdy) begin miscompares++; $display("FAIL rnd%0d_rdy: got %0d want %0d", n, o_rdy, e_rdy); end
      vectors++; if (o_vld !== e_vld) begin miscompares++; $display("FAIL rnd%0d_vld: got %0d want %0d", n, o_vld, e_vld); end
      vectors++; if (o_accw !== e_accw) begin miscompares++; $display("FAIL rnd%0d_accw: got %0d want %0d", n, o_accw, e_accw); end
      vectors++; if (o_txbad !== 0) begin miscompares++; $display("FAIL rnd%0d_txdata: got %0d bad beats want 0", n, o_txbad); end
      vectors++; if (io_result !== m_result) begin miscompares++; $display("FAIL rnd%0d_result: got %h want %h", n, io_result, m_result); end
      vectors++; if (io_error !== m_error) begin miscompares++; $display("FAIL rnd%0d_error: got %b want %b", n, io_error, m_error); end
      vectors++; if (o_post_busy !== 0) begin miscompares++; $display("FAIL rnd%0d_post_busy: got %0d want 0", n, o_post_busy); end
      if (code == 2'd1) begin
        vectors++; if (o_accw_at !== e_busy) begin miscompares++; $display("FAIL rnd%0d_accw_cycle: got %0d want %0d", n, o_accw_at, e_busy); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_code3();
    test_release();
    test_halt();
    test_reset_mid();
`ifdef SYSCALL_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/syscall_unit.md
SYSCALL_UNIT -- requirements
Module: syscall_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width matching ACC/DR.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, wait-cycle limit used only when SYSCALL_TIMEOUT_EN is defined.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port runio  input  1  syscall request from the controller; held high until iobusy is seen low.
REQ-006 SHALL have port acc_in  input  WIDTH  ACC value; its low 2 bits are the function code.
REQ-007 SHALL have port dr_in  input  WIDTH  DR value; the syscall argument.
REQ-008 SHALL have port iobusy  output  1  syscall in progress.
REQ-009 SHALL have port io_result  output  WIDTH  value for the SELACC_IO input of the ACC mux.
REQ-010 SHALL have port io_acc_write  output  1  one-cycle ACC write strobe, ORed with acc_write at top level.
REQ-011 SHALL have ports rx_data (input, WIDTH), rx_valid (input, 1) and rx_ready (output, 1), forming the input word stream.
REQ-012 SHALL have ports tx_data (output, WIDTH), tx_valid (output, 1) and tx_ready (input, 1), forming the output word stream.
REQ-013 SHALL have port halted  output  1  HALT syscall executed.
REQ-014 SHALL have port io_error  output  1  sticky error flag.

Function
REQ-015 SHALL use states IDLE, RD, WR, HALT, DONE and RELEASE.
REQ-016 IDLE with runio=1 at an edge SHALL latch acc_in[1:0] and dr_in, then go: code 0 -> HALT, 1 -> RD, 2 -> WR, 3 -> DONE with io_error set.
REQ-017 iobusy SHALL be combinational: 1 in RD, WR and HALT, 1 in IDLE when runio=1, otherwise 0, so the controller never samples iobusy=0 on the first IOWAIT edge.
REQ-018 RD SHALL drive rx_ready=1; on an edge with rx_valid=1 it SHALL register rx_data into io_result and go to DONE.
REQ-019 WR SHALL drive tx_valid=1 with tx_data equal to the latched DR value; on an edge with tx_ready=1 it SHALL go to DONE, leaving io_result unchanged.
REQ-020 rx_ready and tx_valid SHALL be 0 in every state other than RD and WR respectively.
REQ-021 DONE SHALL last exactly one cycle, with io_acc_write=1 only if the completed call was READ (or a timed-out READ).
REQ-022 On leaving DONE, the unit SHALL go to RELEASE if runio=1, else to IDLE.
REQ-023 RELEASE SHALL stay until runio=0, then go to IDLE, so one request is never serviced twice.
REQ-024 HALT SHALL set halted=1 and keep iobusy=1 until reset; runio SHALL be ignored in HALT.
REQ-025 io_result SHALL hold its value until the next completed READ.
REQ-026 io_error SHALL be sticky, cleared only by reset.
REQ-027 A minimum READ with rx_valid already high SHALL take 3 edges from the edge that raises runio to DONE being visible; WRITE latency is the same.

Reset
REQ-028 With reset=0 at an edge, the unit SHALL return to IDLE and clear io_result, io_acc_write, halted, io_error, the latched code and argument, and the timeout counter.
REQ-029 Reset in RD or WR SHALL drop rx_ready/tx_valid in the following cycle, with no transfer and no ACC write.

Configuration
REQ-030 With SYSCALL_TIMEOUT_EN defined, a counter SHALL count cycles in RD/WR without a handshake.
REQ-031 When that counter reaches TIMEOUT_CYCLES-1, the unit SHALL go to DONE and set io_error; a timed-out READ SHALL load io_result with all ones and strobe io_acc_write.
REQ-032 A handshake on the same edge as the limit SHALL win (normal completion, no error).
REQ-033 Without SYSCALL_TIMEOUT_EN, RD/WR SHALL wait indefinitely and no counter logic SHALL exist.

Verification
REQ-034 READ: acc_in=1, rx_data=0x1234 with rx_valid high, runio pulsed per the controller protocol -> io_result=0x1234; io_acc_write high exactly one cycle; iobusy low at the third edge.
REQ-035 WRITE: acc_in=2, dr_in=0xBEEF, tx_ready held low 5 cycles then high -> tx_valid high 6 cycles with tx_data=0xBEEF; no io_acc_write; iobusy then low.
REQ-036 Code 3: acc_in=3 -> DONE after one busy cycle; io_error=1 and stays 1 across a following valid READ.
REQ-037 HALT: acc_in=0 -> halted=1, iobusy=1 for 100 cycles; reset -> both 0.
REQ-038 runio held high 4 cycles after DONE -> unit stays in RELEASE, no second tx_valid/rx_ready; a new runio afterwards is serviced once.
REQ-039 With SYSCALL_TIMEOUT_EN, TIMEOUT_CYCLES=8, READ with rx_valid=0 -> completion after 8 RD cycles, io_result=0xFFFF, io_error=1.
